// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands the
// fetched word to the decoder over a valid/ready handshake.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 6,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 6'd0,
  parameter logic [3:0]          HALT_OPCODE = 4'b1111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   imem_en,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [PC_WIDTH-1:0]     pc_r;
  logic [PC_WIDTH-1:0]     pc_next_s;
  logic [INSTR_WIDTH-1:0]  ir_r;
  logic                    ir_load_s;
  logic                    ir_valid_r;
  logic                    ir_valid_next_s;
  logic                    halt_op_s;
  logic                    imem_en_s;
  logic                    halted_s;

  assign halt_op_s = (ir_r[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a branch in VALID outranks the decoder handshake
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_next_s = ISSUE;
        else     state_next_s = IDLE;
      end
      ISSUE: begin
        if (branch_valid) state_next_s = ISSUE;
        else              state_next_s = VALID;
      end
      VALID: begin
        if (branch_valid)   state_next_s = ISSUE;
        else if (ir_ready) begin
          if (halt_op_s)    state_next_s = HALT;
          else if (run)     state_next_s = ISSUE;
          else              state_next_s = IDLE;
        end else            state_next_s = VALID;
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    imem_en_s = 1'b0;
    halted_s  = 1'b0;
    case (state_r)
      ISSUE:   imem_en_s = 1'b1;
      HALT:    halted_s  = 1'b1;
      default: begin
        imem_en_s = 1'b0;
        halted_s  = 1'b0;
      end
    endcase
  end

  // Datapath next values: PC, instruction capture and valid flag
  always_comb begin
    pc_next_s       = pc_r;
    ir_load_s       = 1'b0;
    ir_valid_next_s = ir_valid_r;
    case (state_r)
      IDLE: begin
        if (branch_valid) pc_next_s = branch_target;
        else              pc_next_s = pc_r;
      end
      ISSUE: begin
        if (branch_valid) begin
          pc_next_s = branch_target;
        end else begin
          ir_load_s       = 1'b1;
          ir_valid_next_s = 1'b1;
          pc_next_s       = pc_r + PC_ONE;
        end
      end
      VALID: begin
        if (branch_valid) begin
          ir_valid_next_s = 1'b0;
          pc_next_s       = branch_target;
        end else if (ir_ready) begin
          ir_valid_next_s = 1'b0;
        end else begin
          ir_valid_next_s = ir_valid_r;
        end
      end
      HALT:    ir_valid_next_s = 1'b0;
      default: ir_valid_next_s = 1'b0;
    endcase
  end

  // Datapath registers; ir keeps its last word once consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      ir_r       <= {INSTR_WIDTH{1'b0}};
      ir_valid_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      ir_valid_r <= ir_valid_next_s;
      if (ir_load_s) ir_r <= instruction;
    end
  end

  assign pc       = pc_r;
  assign ir       = ir_r;
  assign ir_valid = ir_valid_r;
  assign imem_en  = imem_en_s;
  assign halted   = halted_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a behavioural 64-word instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, run, ir_ready, branch_valid;
  logic [5:0]  branch_target;
  logic [15:0] instruction;
  logic [5:0]  pc;
  logic        imem_en, ir_valid, halted;
  logic [15:0] ir;
  logic [15:0] mem [64];

  int n_checks = 0;
  int n_fails  = 0;
  int step_no  = 0;

  typedef struct {
    logic        rst, run, rdy, bv;
    logic [5:0]  bt;
    logic [5:0]  pc;
    logic        en;
    logic [15:0] ir;
    logic        v, h;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .pc(pc), .imem_en(imem_en), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .branch_valid(branch_valid),
    .branch_target(branch_target), .halted(halted)
  );

  always #5 clk = ~clk;
  assign instruction = mem[pc];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic r, input logic rdy, input logic bv,
                     input logic [5:0] bt, input logic [5:0] epc, input logic een,
                     input logic [15:0] eir, input logic ev, input logic eh);
    vec_t t;
    t.rst = rst; t.run = r; t.rdy = rdy; t.bv = bv; t.bt = bt;
    t.pc = epc; t.en = een; t.ir = eir; t.v = ev; t.h = eh;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs after the edge.
  task automatic apply(input vec_t t);
    reset = t.rst; run = t.run; ir_ready = t.rdy;
    branch_valid = t.bv; branch_target = t.bt;
    @(posedge clk);
    #1;
    check("pc",       {10'd0, pc},       {10'd0, t.pc});
    check("imem_en",  {15'd0, imem_en},  {15'd0, t.en});
    check("ir",       ir,                t.ir);
    check("ir_valid", {15'd0, ir_valid}, {15'd0, t.v});
    check("halted",   {15'd0, halted},   {15'd0, t.h});
    step_no++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h3000 | 16'(i);
    mem[0]  = 16'h1001;
    mem[1]  = 16'h1002;
    mem[2]  = 16'h1003;
    mem[63] = 16'h2AAA;

    //   rst  run  rdy  bv   bt      pc     en   ir         v    h
    // reset held two cycles with run high
    add(1'b1,1'b1,1'b0,1'b0,6'd0,  6'd0, 1'b0,16'h0000,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,6'd0,  6'd0, 1'b0,16'h0000,1'b0,1'b0);
    // sequential fetch
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd0, 1'b1,16'h0000,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd1, 1'b0,16'h1001,1'b1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd1, 1'b1,16'h1001,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd2, 1'b0,16'h1002,1'b1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd2, 1'b1,16'h1002,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd3, 1'b0,16'h1003,1'b1,1'b0);
    // reset while VALID holds 0x1003
    add(1'b1,1'b1,1'b0,1'b0,6'd0,  6'd0, 1'b0,16'h0000,1'b0,1'b0);
    // restart and backpressure on 0x1001
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd0, 1'b1,16'h0000,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd1, 1'b0,16'h1001,1'b1,1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0,1'b1,1'b0,1'b0,6'd0,6'd1, 1'b0,16'h1001,1'b1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd1, 1'b1,16'h1001,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd2, 1'b0,16'h1002,1'b1,1'b0);
    // branch in VALID beats a ready decoder
    add(1'b0,1'b1,1'b1,1'b1,6'd40, 6'd40,1'b1,16'h1002,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd41,1'b0,16'h3028,1'b1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd41,1'b1,16'h3028,1'b0,1'b0);
    // branch in ISSUE discards mem[41] and refetches at 40
    add(1'b0,1'b1,1'b1,1'b1,6'd40, 6'd40,1'b1,16'h3028,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd41,1'b0,16'h3028,1'b1,1'b0);
    // run low at handshake returns to IDLE; branch while IDLE
    add(1'b0,1'b0,1'b1,1'b0,6'd0,  6'd41,1'b0,16'h3028,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,6'd0,  6'd41,1'b0,16'h3028,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,6'd62, 6'd62,1'b0,16'h3028,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd62,1'b1,16'h3028,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd63,1'b0,16'h303E,1'b1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,6'd0,  6'd63,1'b1,16'h303E,1'b0,1'b0);
    // fetch at 63 wraps the PC to 0
    add(1'b0,1'b1,1'b0,1'b0,6'd0,  6'd0, 1'b0,16'h2AAA,1'b1,1'b0);

    foreach (vecs[k]) apply(vecs[k]);

    // Halt: fetch 0xF000 from address 0, then nothing but reset moves the unit
    mem[0] = 16'hF000;
    begin
      vec_t t;
      t = '{1'b0,1'b1,1'b1,1'b0,6'd0, 6'd0,1'b1,16'h2AAA,1'b0,1'b0}; apply(t);
      t = '{1'b0,1'b1,1'b1,1'b0,6'd0, 6'd1,1'b0,16'hF000,1'b1,1'b0}; apply(t);
      t = '{1'b0,1'b1,1'b1,1'b0,6'd0, 6'd1,1'b0,16'hF000,1'b0,1'b1}; apply(t);
      for (int i = 0; i < 6; i++) begin
        t = '{1'b0,1'b1,1'b1,i[0],6'd17, 6'd1,1'b0,16'hF000,1'b0,1'b1};
        apply(t);
      end
      mem[0] = 16'h1001;
      t = '{1'b1,1'b1,1'b0,1'b0,6'd0, 6'd0,1'b0,16'h0000,1'b0,1'b0}; apply(t);
      t = '{1'b0,1'b1,1'b0,1'b0,6'd0, 6'd0,1'b1,16'h0000,1'b0,1'b0}; apply(t);
      t = '{1'b0,1'b1,1'b0,1'b0,6'd0, 6'd1,1'b0,16'h1001,1'b1,1'b0}; apply(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
